// File: rtl/dump_seq_pkg.sv
// rtl/dump_seq_pkg.sv - shared types, dump address map and address sequencing helpers
package dump_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEQ   = 2'd1,
        FLUSH = 2'd2,
        ACK   = 2'd3
    } dump_state_e;

    localparam logic [4:0] ADDR_PRN_STATE   = 5'd6;
    localparam logic [4:0] ADDR_CODE_PHASE  = 5'd10;
    localparam logic [4:0] ADDR_MS_DATA_SUM = 5'd13;
    localparam logic [4:0] ADDR_PRN2_STATE  = 5'd15;
    localparam logic [4:0] ADDR_ACC_BASE    = 5'd16;
    localparam int         BASE_WORDS       = 9;

    // Word 14 is not part of the dump map, so the list jumps from 13 to 15.
    function automatic logic [4:0] next_addr(input logic [4:0] a);
        return (a == ADDR_MS_DATA_SUM) ? ADDR_PRN2_STATE : a + 5'd1;
    endfunction

    function automatic logic [4:0] last_addr(input logic acc, input int acc_words);
        return acc ? ADDR_ACC_BASE + 5'(acc_words - 1) : ADDR_PRN2_STATE;
    endfunction

endpackage

// File: rtl/dump_sequencer_if.sv
// rtl/dump_sequencer_if.sv - request, dump multiplexer and state buffer signals of the dump sequencer
interface dump_seq_if #(
    parameter int CH_AW = 5
) ();
    logic [3:0]       dump_req;
    logic [3:0]       dump_acc_en;
    logic [CH_AW-1:0] logic_ch_0;
    logic [CH_AW-1:0] logic_ch_1;
    logic [CH_AW-1:0] logic_ch_2;
    logic [CH_AW-1:0] logic_ch_3;
    logic [1:0]       physical_channel_index;
    logic [4:0]       state_addr;
    logic [31:0]      state_d4wt;
    logic             state_we;
    logic [CH_AW+4:0] state_waddr;
    logic [31:0]      state_wdata;
    logic             dump_busy;
    logic [3:0]       dump_active;
    logic [3:0]       dump_ack;

    modport master (
        output dump_req, dump_acc_en, logic_ch_0, logic_ch_1, logic_ch_2, logic_ch_3, state_d4wt,
        input  physical_channel_index, state_addr, state_we, state_waddr, state_wdata,
               dump_busy, dump_active, dump_ack
    );

    modport slave (
        input  dump_req, dump_acc_en, logic_ch_0, logic_ch_1, logic_ch_2, logic_ch_3, state_d4wt,
        output physical_channel_index, state_addr, state_we, state_waddr, state_wdata,
               dump_busy, dump_active, dump_ack
    );
endinterface

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - pending dump latch with four-way round-robin grant
module rr_arbiter_4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] acc_en,
    input  logic       grant_en,
    output logic       any_pend,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_acc
);
    logic [3:0] pend;
    logic [3:0] acc_pend;
    logic [1:0] ptr;

    always_comb begin
        logic       found;
        logic [1:0] idx;
        found     = 1'b0;
        idx       = ptr;
        grant_idx = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && pend[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        any_pend  = |pend;
        grant     = (grant_en && any_pend) ? (4'b0001 << grant_idx) : 4'b0000;
        grant_acc = acc_pend[grant_idx];
    end

    // A request landing on the grant cycle survives the clear, so that channel is dumped again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= 4'b0000;
            acc_pend <= 4'b0000;
            ptr      <= 2'd0;
        end else begin
            pend     <= (pend & ~grant) | req;
            acc_pend <= (acc_pend & ~req) | (acc_en & req);
            if (|grant) begin
                ptr <= grant_idx + 2'd1;
            end
        end
    end
endmodule

// File: rtl/dump_sequencer.sv
// rtl/dump_sequencer.sv - time-shares the state dump multiplexer and writes dumped words to the state buffer
module dump_sequencer
    import dump_seq_pkg::*;
#(
    parameter int CH_AW     = 5,
    parameter int ACC_WORDS = 8
) (
    input  logic       clk,
    input  logic       rst,
    dump_seq_if.slave  bus
);
    dump_state_e      state, state_nxt;
    logic             any_pend, grant_acc, last;
    logic [3:0]       grant, gidx_onehot;
    logic [1:0]       grant_idx, gidx_q;
    logic             acc_q, we_q;
    logic [CH_AW-1:0] lch_sel, lch_q;
    logic [4:0]       addr_q, waddr_lo_q;

    rr_arbiter_4 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.dump_req),
        .acc_en    (bus.dump_acc_en),
        .grant_en  (state == IDLE),
        .any_pend  (any_pend),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_acc (grant_acc)
    );

    always_comb begin
        case (grant_idx)
            2'd0:    lch_sel = bus.logic_ch_0;
            2'd1:    lch_sel = bus.logic_ch_1;
            2'd2:    lch_sel = bus.logic_ch_2;
            default: lch_sel = bus.logic_ch_3;
        endcase
    end

    assign last = (addr_q == last_addr(acc_q, ACC_WORDS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_pend) state_nxt = SEQ;
            SEQ:     if (last) state_nxt = FLUSH;
            FLUSH:   state_nxt = ACK;
            default: state_nxt = IDLE;
        endcase
    end

    // The write trails the address by one cycle to match the registered mux word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gidx_q     <= 2'd0;
            acc_q      <= 1'b0;
            lch_q      <= '0;
            addr_q     <= 5'd0;
            we_q       <= 1'b0;
            waddr_lo_q <= 5'd0;
        end else begin
            we_q       <= (state == SEQ);
            waddr_lo_q <= addr_q;
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        gidx_q <= grant_idx;
                        acc_q  <= grant_acc;
                        lch_q  <= lch_sel;
                        addr_q <= ADDR_PRN_STATE;
                    end
                end
                SEQ:     addr_q <= last ? 5'd0 : next_addr(addr_q);
                default: addr_q <= 5'd0;
            endcase
        end
    end

    assign gidx_onehot = 4'b0001 << gidx_q;

    always_comb begin
        bus.dump_busy   = (state == SEQ) || (state == FLUSH);
        bus.dump_active = bus.dump_busy ? gidx_onehot : 4'b0000;
        bus.dump_ack    = (state == ACK) ? gidx_onehot : 4'b0000;
    end

    assign bus.physical_channel_index = gidx_q;
    assign bus.state_addr             = addr_q;
    assign bus.state_we               = we_q;
    assign bus.state_waddr            = {lch_q, waddr_lo_q};
    assign bus.state_wdata            = bus.state_d4wt;
endmodule

// File: tb/tb_dump_sequencer.sv
// tb/tb_dump_sequencer.sv - directed self-checking bench for dump_sequencer
module tb_dump_sequencer;
    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    dump_seq_if #(.CH_AW(5)) bus ();

    dump_sequencer #(.CH_AW(5), .ACC_WORDS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mux_word(input logic [1:0] p, input logic [4:0] a);
        return 32'hD000_0000 | {22'd0, p, 3'd0, a};
    endfunction

    // Registered dump multiplexer model: word appears one cycle after the address.
    always @(posedge clk or posedge rst) begin
        if (rst) bus.state_d4wt <= 32'd0;
        else     bus.state_d4wt <= mux_word(bus.physical_channel_index, bus.state_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] r, input logic [3:0] acc);
        bus.dump_req    = r;
        bus.dump_acc_en = acc;
        step();
        bus.dump_req    = 4'b0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_grant(input logic [3:0] exp, input string tag, output int t_grant);
        int   n;
        logic overlap;
        n = 0;
        while (bus.dump_active == 4'b0000 && n < 60) begin
            step();
            n++;
        end
        t_grant = cyc;
        chk({tag, " grant"}, 32'(bus.dump_active), 32'(exp));
        overlap = 1'b0;
        n = 0;
        while (bus.dump_ack == 4'b0000 && n < 60) begin
            if (!$onehot0(bus.dump_active)) overlap = 1'b1;
            step();
            n++;
        end
        chk({tag, " ack"}, 32'(bus.dump_ack), 32'(exp));
        chk({tag, " onehot"}, 32'(overlap), 32'd0);
    endtask

    logic [4:0] lst [9];
    int t0, t1, t2, t3, tx;
    int wr_cnt, ack_k, last_a, last_wa, n;
    logic seen;

    initial begin
        lst = '{5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd15};
        rst = 1'b1;
        bus.dump_req    = 4'b0000;
        bus.dump_acc_en = 4'b0000;
        bus.logic_ch_0  = 5'd3;
        bus.logic_ch_1  = 5'd31;
        bus.logic_ch_2  = 5'd5;
        bus.logic_ch_3  = 5'd9;
        step();
        step();
        chk("rst addr",   32'(bus.state_addr), 32'd0);
        chk("rst we",     32'(bus.state_we), 32'd0);
        chk("rst waddr",  32'(bus.state_waddr), 32'd0);
        chk("rst busy",   32'(bus.dump_busy), 32'd0);
        chk("rst active", 32'(bus.dump_active), 32'd0);
        chk("rst ack",    32'(bus.dump_ack), 32'd0);
        chk("rst pci",    32'(bus.physical_channel_index), 32'd0);
        rst = 1'b0;
        step();

        // Single request on channel 2, logical channel 5
        pulse(4'b0100, 4'b0000);
        chk("t1 idle busy", 32'(bus.dump_busy), 32'd0);
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k <= 9) chk("t1 addr", 32'(bus.state_addr), 32'(lst[k-1]));
            else        chk("t1 addr end", 32'(bus.state_addr), 32'd0);
            if (k >= 2 && k <= 10) begin
                chk("t1 we", 32'(bus.state_we), 32'd1);
                chk("t1 waddr", 32'(bus.state_waddr), 32'd160 + 32'(lst[k-2]));
                chk("t1 wdata", bus.state_wdata, mux_word(2'd2, lst[k-2]));
            end else begin
                chk("t1 we off", 32'(bus.state_we), 32'd0);
            end
            if (k <= 10) chk("t1 pci", 32'(bus.physical_channel_index), 32'd2);
            chk("t1 active", 32'(bus.dump_active), (k <= 10) ? 32'd4 : 32'd0);
            chk("t1 ack", 32'(bus.dump_ack), (k == 11) ? 32'd4 : 32'd0);
        end
        step();
        chk("t1 post busy", 32'(bus.dump_busy), 32'd0);

        // All four channels at once from the reset pointer
        do_reset();
        pulse(4'b1111, 4'b0000);
        wait_grant(4'b0001, "t2 ch0", t0);
        wait_grant(4'b0010, "t2 ch1", t1);
        wait_grant(4'b0100, "t2 ch2", t2);
        wait_grant(4'b1000, "t2 ch3", t3);
        chk("t2 gap01", 32'(t1 - t0), 32'd12);
        chk("t2 gap12", 32'(t2 - t1), 32'd12);
        chk("t2 gap23", 32'(t3 - t2), 32'd12);

        // Channels 0 and 3 requested while 2 dumps: pointer sits at 3
        step();
        pulse(4'b0100, 4'b0000);
        step();
        step();
        chk("t2b active", 32'(bus.dump_active), 32'd4);
        pulse(4'b1001, 4'b0000);
        n = 0;
        while (bus.dump_ack == 4'b0000 && n < 40) begin step(); n++; end
        chk("t2b ack2", 32'(bus.dump_ack), 32'd4);
        wait_grant(4'b1000, "t2b ch3", tx);
        wait_grant(4'b0001, "t2b ch0", tx);

        // Accumulator dump, logical channel 31
        do_reset();
        pulse(4'b0010, 4'b0010);
        wr_cnt = 0; ack_k = -1; last_a = -1; last_wa = -1;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (bus.state_we) begin
                wr_cnt++;
                last_wa = int'(bus.state_waddr);
            end
            if (bus.dump_busy && bus.state_addr != 5'd0) last_a = int'(bus.state_addr);
            if (bus.dump_ack != 4'b0000 && ack_k < 0) ack_k = k;
        end
        chk("t3 writes", 32'(wr_cnt), 32'd17);
        chk("t3 last addr", 32'(last_a), 32'd23);
        chk("t3 last waddr", 32'(last_wa), 32'd1015);
        chk("t3 ack cycle", 32'(ack_k), 32'd19);

        // Reset in SEQ cycle 4 of channel 1 with channel 3 pending
        do_reset();
        bus.dump_acc_en = 4'b0000;
        pulse(4'b0010, 4'b0000);
        step();
        step();
        pulse(4'b1000, 4'b0000);
        step();
        chk("t4 addr c4", 32'(bus.state_addr), 32'd9);
        rst = 1'b1;
        #1;
        chk("t4 addr",   32'(bus.state_addr), 32'd0);
        chk("t4 we",     32'(bus.state_we), 32'd0);
        chk("t4 waddr",  32'(bus.state_waddr), 32'd0);
        chk("t4 wdata",  bus.state_wdata, 32'd0);
        chk("t4 busy",   32'(bus.dump_busy), 32'd0);
        chk("t4 active", 32'(bus.dump_active), 32'd0);
        chk("t4 ack",    32'(bus.dump_ack), 32'd0);
        chk("t4 pci",    32'(bus.physical_channel_index), 32'd0);
        step();
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.dump_busy || bus.dump_ack != 4'b0000 || bus.state_we) seen = 1'b1;
        end
        chk("t4 stays idle", 32'(seen), 32'd0);

        // Channel 0 re-requests during its own dump
        do_reset();
        pulse(4'b0001, 4'b0000);
        step();
        step();
        chk("t5 active", 32'(bus.dump_active), 32'd1);
        pulse(4'b0001, 4'b0000);
        n = 0;
        while (bus.dump_ack == 4'b0000 && n < 40) begin step(); n++; end
        chk("t5 ack0", 32'(bus.dump_ack), 32'd1);
        step();
        chk("t5 regrant idle", 32'(bus.dump_active), 32'd0);
        step();
        chk("t5 regrant", 32'(bus.dump_active), 32'd1);
        step();
        pulse(4'b0101, 4'b0000);
        n = 0;
        while (bus.dump_ack == 4'b0000 && n < 40) begin step(); n++; end
        chk("t5 ack0 again", 32'(bus.dump_ack), 32'd1);
        wait_grant(4'b0100, "t5 ch2", tx);
        wait_grant(4'b0001, "t5 ch0", tx);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dump_sequencer.md
Name: dump_sequencer

Overview:
Controller that time-shares the four-channel state dump multiplexer among the physical correlator channels.
- Accepts per-channel dump requests and arbitrates round-robin.
- Drives physical_channel_index and state_addr through the fixed dump address list.
- Writes each registered state word to the state buffer at {logical channel, word address}.
- Sits between the correlator channels / tracking-engine scheduler and the state memory.

Parameters:
CH_AW, 5, logical channel index width; state buffer address width is CH_AW+5.
ACC_WORDS, 8, correlator accumulator words dumped when accumulator dump is enabled (1..16).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
dump_req  in  4  per-physical-channel single-cycle request pulse
dump_acc_en  in  4  per-channel accumulator-dump enable, sampled with dump_req
logic_ch_0..logic_ch_3  in  CH_AW each  logical channel index of each physical channel, sampled at grant
physical_channel_index  out  2  channel select to the dump multiplexer
state_addr  out  5  word select to the dump multiplexer
state_d4wt  in  32  registered dump word, valid 1 cycle after state_addr
state_we  out  1  state buffer write strobe
state_waddr  out  CH_AW+5  state buffer write address
state_wdata  out  32  equals state_d4wt (combinational pass-through)
dump_busy  out  1  sequence in progress
dump_active  out  4  one-hot channel being dumped; the channel holds its state while its bit is set
dump_ack  out  4  one-cycle pulse: dump of that channel complete

Behaviour:
- Reset values (asserted asynchronously): all outputs 0; pending bits 0; round-robin pointer 0; FSM in IDLE.
- Pending latch: a dump_req[i] pulse sets pend[i] and acc_pend[i] <= dump_acc_en[i].
  - A request on a channel already pending merges and takes the newest acc_en.
  - A request in the same cycle as that channel's grant leaves pend set, so the channel is re-dumped later.
- Arbitration, in IDLE only:
  - Search from pointer ptr upward, modulo 4, for the first pend bit.
  - On grant g: clear pend[g]; latch acc flag and logic_ch_g; set ptr = g+1 mod 4.
  - After reset the priority order is 0,1,2,3.
- Address list, in order: 6,7,8,9,10,11,12,13,15.
  - If the acc flag is set, continue with 16 .. 16+ACC_WORDS-1.
  - N = 9 or 9+ACC_WORDS.
- FSM states:
  - IDLE: if any pend, grant, load state_addr=6, set dump_busy and dump_active, go to SEQ.
  - SEQ: state_addr holds the current list entry for one cycle, then advances (13→15, 15→16 or end). After the last entry, state_addr=0 and go to FLUSH. SEQ occupies N cycles.
  - FLUSH: last write completes; go to ACK.
  - ACK: dump_ack[g]=1 for one cycle; clear dump_busy and dump_active; go to IDLE.
- Write pipeline:
  - state_we=1 in the cycle after each SEQ address cycle.
  - state_waddr = {logic_ch latched, state_addr delayed 1 cycle}.
- Timing: a request pending with the FSM in IDLE in cycle 0 gives SEQ cycles 1..N, writes in cycles 2..N+1, FLUSH at N+1, ACK at N+2. The next grant is possible at N+3.
- physical_channel_index holds g from grant through FLUSH.
- Reset mid-sequence: abort immediately; no ack; the aborted channel is not re-pended.
- dump_req and logic_ch changes during a sequence do not affect the running sequence.

Decomposition:
- Package dump_seq_pkg:
  - FSM state enum {IDLE, SEQ, FLUSH, ACK}.
  - Address constants: ADDR_PRN_STATE=6, ADDR_CODE_PHASE=10, ADDR_MS_DATA_SUM=13, ADDR_PRN2_STATE=15, ADDR_ACC_BASE=16, BASE_WORDS=9.
  - next_addr function.
- One sub-module: rr_arbiter_4, holding the pending mask, pointer, and one-hot grant plus index.

Test Plan:
- Single request:
  - Stimulus: after reset, dump_req=4'b0100, logic_ch_2=5, acc off.
  - Response: state_addr 6..13,15 in cycles 1..9; state_we in cycles 2..10; waddr 166..173,175; dump_ack=4'b0100 at cycle 11; state_wdata equals the mux word for each address.
- All four channels:
  - Stimulus: dump_req=4'b1111 in one cycle.
  - Response: grants in order 0,1,2,3, each 12 cycles apart; dump_active is one-hot and never overlaps.
  - Follow-on: then pulse channels 0 and 3 while channel 2 is dumping; next grant is 3, then 0.
- Accumulator dump:
  - Stimulus: acc on, ACC_WORDS=8, logic_ch=31.
  - Response: 17 writes; last state_addr is 23 and last waddr is 1015; ack in cycle 19.
- Reset mid-sequence:
  - Stimulus: assert rst during SEQ cycle 4 of channel 1, with pend[3] set.
  - Response: all outputs 0 immediately; no ack; after release with no new requests the FSM stays in IDLE.
- Re-request during own dump:
  - Stimulus: pulse dump_req[0] while channel 0 is in SEQ.
  - Response: channel 0 is acked, then re-granted at ack+1; no other channel is starved when others are pending (round-robin order holds).
